// File: rtl/receiver_control_unit_pkg.sv
// receiver_control_unit_pkg: FSM state encodings for the UART receiver control path
package receiver_control_unit_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
endpackage

// File: rtl/receiver_control_unit_bit_counter.sv
// receiver_control_unit_bit_counter: data-bit counter with clear/enable and terminal-count compare
module receiver_control_unit_bit_counter #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 7
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);
  logic [WIDTH-1:0] r_count;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_enable) r_count <= r_count + 1'b1;
  assign o_terminal = r_count == WIDTH'(TERMINAL);
endmodule

// File: rtl/receiver_control_unit.sv
// receiver_control_unit: UART receiver control FSM (start detect, bit windows, frame status)
// Optional parity window and check enabled by RECEIVER_PARITY_EN.
module receiver_control_unit
  import receiver_control_unit_pkg::*;
#(
  parameter int DATA_BITS       = 8,
  parameter int BIT_COUNT_WIDTH = 4
`ifdef RECEIVER_PARITY_EN
  , parameter bit PARITY_ODD    = 1'b0
`endif
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_rx,
  input  logic i_clock_equal,
  output logic o_state_is_START,
  output logic o_state_is_DATA,
  output logic o_state_is_STOP,
  output logic o_shift_enable,
  output logic o_data_valid,
  output logic o_framing_error,
  output logic o_parity_error,
  output logic o_busy
);
`ifdef RECEIVER_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t r_state, w_next;
  logic r_rx_meta, r_rx_s, r_armed, r_data_valid, r_framing_error;
  logic w_data_entry, w_shift, w_last, w_stop_exit;
  assign w_data_entry = r_state == START && i_clock_equal && !r_rx_s;
  assign w_shift      = r_state == DATA && i_clock_equal;
  assign w_stop_exit  = r_state == STOP && i_clock_equal;
  receiver_control_unit_bit_counter #(
    .WIDTH   (BIT_COUNT_WIDTH),
    .TERMINAL(DATA_BITS - 1)
  ) u_bit_counter (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (w_data_entry),
    .i_enable  (w_shift),
    .o_terminal(w_last)
  );
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (!r_rx_s && r_armed) w_next = START;
      START:   if (i_clock_equal) w_next = r_rx_s ? IDLE : DATA;
      DATA:    if (w_shift && w_last) w_next = AFTER_DATA;
      PARITY:  if (i_clock_equal) w_next = STOP;
      STOP:    if (i_clock_equal) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  // armed drops on a framing error so a held-low break cannot retrigger START
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_rx_meta       <= 1'b1;
      r_rx_s          <= 1'b1;
      r_state         <= IDLE;
      r_armed         <= 1'b0;
      r_data_valid    <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_rx_meta       <= i_rx;
      r_rx_s          <= r_rx_meta;
      r_state         <= w_next;
      r_armed         <= (r_state == IDLE && r_rx_s) ? 1'b1 : (w_stop_exit && !r_rx_s) ? 1'b0 : r_armed;
      r_data_valid    <= w_stop_exit && r_rx_s;
      r_framing_error <= w_stop_exit && !r_rx_s;
    end
`ifdef RECEIVER_PARITY_EN
  logic r_parity, r_parity_bad, r_parity_error;
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      r_parity       <= 1'b0;
      r_parity_bad   <= 1'b0;
      r_parity_error <= 1'b0;
    end else begin
      r_parity       <= w_data_entry ? 1'b0 : w_shift ? r_parity ^ r_rx_s : r_parity;
      r_parity_bad   <= (r_state == PARITY && i_clock_equal) ? r_rx_s != (r_parity ^ PARITY_ODD) : r_parity_bad;
      r_parity_error <= w_stop_exit && r_parity_bad;
    end
  assign o_parity_error = r_parity_error;
`else
  assign o_parity_error = 1'b0;
`endif
  assign o_state_is_START = r_state == START;
  assign o_state_is_DATA  = r_state == DATA || r_state == PARITY;
  assign o_state_is_STOP  = r_state == STOP;
  assign o_shift_enable   = w_shift;
  assign o_data_valid     = r_data_valid;
  assign o_framing_error  = r_framing_error;
  assign o_busy           = r_state != IDLE;
endmodule
